// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: data width, fetch FSM states,
// the instruction buffer entry layout and the word-alignment helper.
package cpu_pkg;

    localparam int XLEN = 32;

    // Value driven on the instruction bus when no instruction is presented.
    localparam logic [XLEN-1:0] ZERO_INSTR = '0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One instruction buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: a DEPTH-entry circular FIFO of
// {pc, instr} entries with a synchronous flush. Pointers and count are reset;
// the storage array is not, since nothing reads it while the count is zero.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic               not_empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               do_push;
    logic               do_pop;

    // Advance a pointer around a ring that need not be a power of two long.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    // A flush wins over any push/pop arriving in the same cycle.
    assign do_push   = push & ~flush & ~full;
    assign do_pop    = pop & ~flush & ~empty;
    assign head      = mem[rd_ptr];
    assign not_empty = ~empty;

    // Pointer and occupancy bookkeeping, cleared by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues sequential word fetches to an in-order
// instruction memory, buffers returned words with their PCs, and hands them
// to decode over a valid/ready link. A redirect flushes the buffer and
// discards every response still owed for the old path before refetching.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [XLEN-1:0]    fetch_pc_q;
    logic [XLEN-1:0]    fetch_pc_d;
    logic [XLEN-1:0]    rsp_pc_q;
    logic [XLEN-1:0]    rsp_pc_d;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;
    logic [CNT_W-1:0]   drop_q;
    logic [CNT_W-1:0]   drop_d;
    logic [CNT_W-1:0]   occupancy;
    logic [SUM_W-1:0]   pending;
    logic               has_room;
    logic               req_fire;
    logic               instr_fire;
    logic               rsp_drop;
    logic               rsp_keep;
    logic               head_valid;
    fetch_entry_t       head_entry;
    fetch_entry_t       push_entry;

    // Requests outstanding at memory plus words already buffered; capped at DEPTH.
    assign pending    = SUM_W'(inflight_q) + SUM_W'(occupancy);
    assign has_room   = (pending < SUM_W'(DEPTH));
    assign req_fire   = imem_req_valid & imem_req_ready;
    assign instr_fire = instr_valid & instr_ready;
    // Responses in a redirect cycle or while old-path responses are owed are stale.
    assign rsp_drop   = imem_rsp_valid & (redirect_valid | (drop_q != '0));
    assign rsp_keep   = imem_rsp_valid & ~rsp_drop;

    assign imem_req_addr = fetch_pc_q;

    // Kept responses always belong to the current path, which is contiguous
    // from the last redirect target, so their PC is tracked by rsp_pc_q.
    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (instr_fire),
        .head      (head_entry),
        .not_empty (head_valid),
        .count     (occupancy)
    );

    // Decode-side outputs are forced to zero whenever no entry is presented.
    assign instr_valid = head_valid;
    assign instr       = head_valid ? head_entry.instr : ZERO_INSTR;
    assign pc          = head_valid ? head_entry.pc    : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // FSM next-state: BOOT lasts one cycle; redirect picks DRAIN only if stale responses are owed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid) state_d = (drop_d != '0) ? DRAIN : RUN;
            end
            DRAIN: begin
                if (redirect_valid)     state_d = (drop_d != '0) ? DRAIN : RUN;
                else if (drop_d == '0)  state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: request only in RUN, never alongside a redirect, and only with room.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state_q == RUN) && !redirect_valid && has_room) imem_req_valid = 1'b1;
    end

    // Next values for fetch/response PCs and the in-flight and drop counters.
    always_comb begin
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        drop_d = drop_q;
        if (redirect_valid)  drop_d = inflight_d;
        else if (rsp_drop)   drop_d = drop_q - CNT_W'(1);

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)  fetch_pc_d = word_align(redirect_pc);
        else if (req_fire)   fetch_pc_d = fetch_pc_q + XLEN'(4);

        rsp_pc_d = rsp_pc_q;
        if (redirect_valid)  rsp_pc_d = word_align(redirect_pc);
        else if (rsp_keep)   rsp_pc_d = rsp_pc_q + XLEN'(4);
    end

    // Fetch bookkeeping registers; reset aborts all outstanding fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // A response can only answer an outstanding request.
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (inflight_q != '0));

    // Outstanding plus buffered work never exceeds the buffer size.
    a_no_overcommit: assert property (@(posedge clk) disable iff (!rst_n)
        pending <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios for boot, backpressure,
// redirect/drain, redirect-with-handshake, PC wrap and mid-flight reset,
// plus a randomized phase, all scored against a transaction-level model
// (address stream, epoch-tagged memory queue, expected delivery queue).
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    mem_req_t    mq[$];      // requests accepted by memory, oldest first
    logic [63:0] dq[$];      // {pc, instr} the decoder is still owed, in order

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          deliveries = 0;
    int          drops = 0;
    logic [31:0] exp_fetch = RST_PC;

    // Stimulus knobs applied at the next falling edge.
    logic        d_rst_n = 1'b0;
    logic        d_req_ready = 1'b0;
    logic        d_instr_ready = 1'b0;
    logic        d_redirect = 1'b0;
    logic [31:0] d_redirect_pc = '0;
    bit          rand_rsp = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;

    // Observations from the most recent step.
    logic        s_req_valid, s_accept, s_rsp, s_instr_valid;
    logic [31:0] s_req_addr, s_instr, s_pc;
    logic        stall_prev = 1'b0;
    logic [64:0] stall_snap = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, sample 1 time unit later,
    // score against the model, then let the rising edge happen.
    task automatic step();
        mem_req_t r;
        @(negedge clk);
        rst_n          = d_rst_n;
        imem_req_ready = d_req_ready;
        instr_ready    = d_instr_ready;
        redirect_valid = d_redirect;
        redirect_pc    = d_redirect_pc;
        s_rsp = (rst_n && mq.size() > 0 && mq[0].due <= cyc && (!rand_rsp || $urandom_range(0, 1) == 1));
        imem_rsp_valid = s_rsp;
        imem_rsp_data  = s_rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr       = instr;
        s_pc          = pc;
        s_accept      = rst_n && s_req_valid && d_req_ready;
        if (!rst_n) begin
            check("reset_outputs", {s_req_valid, s_instr_valid, s_instr, s_pc}, '0);
            stall_prev = 1'b0;
        end else begin
            if (d_redirect) check("no_req_on_redirect", s_req_valid, 1'b0);
            if (s_accept) begin
                check("req_addr", s_req_addr, exp_fetch);
                mq.push_back('{addr: exp_fetch, epoch: epoch, due: cyc + $urandom_range(lat_min, lat_max)});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (!s_instr_valid) check("idle_zero", {s_pc, s_instr}, '0);
            if (stall_prev) check("stall_hold", {s_instr_valid, s_pc, s_instr}, stall_snap);
            if (s_instr_valid) begin
                if (dq.size() == 0) begin
                    check("instr_unexpected", {s_pc, s_instr}, '1);
                end else begin
                    check("instr", {s_pc, s_instr}, dq[0]);
                    if (d_instr_ready) begin
                        void'(dq.pop_front());
                        deliveries++;
                    end
                end
            end
            stall_prev = s_instr_valid && !d_instr_ready && !d_redirect;
            stall_snap = {1'b1, s_pc, s_instr};
            if (d_redirect) begin
                dq.delete();
                epoch++;
                exp_fetch = d_redirect_pc & ~32'h3;
            end
            if (s_rsp) begin
                r = mq.pop_front();
                if (r.epoch == epoch) dq.push_back({r.addr, mem_word(r.addr)});
                else drops++;
            end
            check("capacity", (mq.size() + dq.size()) <= DEPTH, 1'b1);
        end
        @(posedge clk);
        cyc++;
    endtask

    // Assert reset asynchronously between edges; the memory side resets with it.
    task automatic apply_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        d_rst_n = 1'b0;
        mq.delete();
        dq.delete();
        epoch++;
        exp_fetch = RST_PC;
        stall_prev = 1'b0;
        #1;
        check("async_reset", {imem_req_valid, instr_valid, instr, pc}, '0);
        repeat (cycles) step();
        d_rst_n = 1'b1;
    endtask

    task automatic step_until_accept(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_accept && n < limit);
    endtask

    task automatic go_idle(input int cycles);
        d_req_ready = 1'b0;
        d_instr_ready = 1'b1;
        d_redirect = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        int n;
        int d0;
        int dr0;
        int rand_deliv;

        // Boot, first fetches and first delivery latency.
        lat_min = 1; lat_max = 1; rand_rsp = 1'b0;
        d_req_ready = 1'b1; d_instr_ready = 1'b0;
        apply_reset(3);
        step();
        check("boot_no_req", s_req_valid, 1'b0);
        step();
        check("first_req", {s_accept, s_req_addr}, {1'b1, RST_PC});
        step();
        check("second_req", {s_accept, s_req_addr}, {1'b1, RST_PC + 32'd4});
        check("no_instr_yet", s_instr_valid, 1'b0);
        step();
        check("first_instr", {s_instr_valid, s_pc, s_instr}, {1'b1, RST_PC, mem_word(RST_PC)});

        // Backpressure: decoder stalls, buffer fills, requests stop.
        repeat (5) step();
        check("bp_req_blocked", s_req_valid, 1'b0);
        check("bp_head", {s_instr_valid, s_pc, s_instr}, {1'b1, RST_PC, mem_word(RST_PC)});
        check("bp_buffered", dq.size(), 2);
        check("bp_inflight", mq.size(), 0);
        d_instr_ready = 1'b1;
        step_until_accept(10, n);
        check("third_req", {s_accept, s_req_addr}, {1'b1, RST_PC + 32'd8});

        // Redirect with two fetches in flight on a 3-cycle memory.
        go_idle(8);
        lat_min = 3; lat_max = 3;
        d_req_ready = 1'b1;
        step();
        step();
        check("rd_inflight", mq.size(), 2);
        dr0 = drops;
        d_redirect = 1'b1; d_redirect_pc = 32'h0000_0203;
        step();
        d_redirect = 1'b0;
        step_until_accept(12, n);
        check("drain_cycles", n - 1, 2);
        check("drain_next_req", {s_accept, s_req_addr}, {1'b1, 32'h0000_0200});
        check("drain_dropped", drops - dr0, 2);
        n = 0;
        do begin step(); n++; end while (!s_instr_valid && n < 12);
        check("drain_first_pc", {s_instr_valid, s_pc}, {1'b1, 32'h0000_0200});

        // Redirect in the same cycle as a decoder handshake and a response.
        lat_min = 1; lat_max = 1;
        go_idle(8);
        d_req_ready = 1'b1;
        step();
        step();
        d0 = deliveries; dr0 = drops;
        d_redirect = 1'b1; d_redirect_pc = 32'h0000_0400;
        step();
        check("hs_setup", {s_instr_valid, s_rsp, d_instr_ready}, 3'b111);
        check("hs_counted", deliveries - d0, 1);
        check("hs_dropped", drops - dr0, 1);
        d_redirect = 1'b0; d_req_ready = 1'b0;
        step();
        check("hs_flushed", s_instr_valid, 1'b0);

        // Fetch PC wraps past the top of the address space.
        d_req_ready = 1'b1;
        d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFFC;
        step();
        d_redirect = 1'b0;
        step_until_accept(12, n);
        check("wrap_req0", {s_accept, s_req_addr}, {1'b1, 32'hFFFF_FFFC});
        step_until_accept(12, n);
        check("wrap_req1", {s_accept, s_req_addr}, {1'b1, 32'h0000_0000});

        // Randomized traffic: random ready, latency, response timing and redirects.
        lat_min = 1; lat_max = 4; rand_rsp = 1'b1;
        rand_deliv = deliveries;
        for (int i = 0; i < 3000; i++) begin
            d_req_ready   = ($urandom_range(0, 3) != 0);
            d_instr_ready = ($urandom_range(0, 3) != 0);
            d_redirect    = ($urandom_range(0, 19) == 0);
            d_redirect_pc = $urandom;
            if ($urandom_range(0, 3) == 0) d_redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step();
        end
        check("rand_progress", (deliveries - rand_deliv) >= 200, 1'b1);

        // Reset mid-operation with work in flight and buffered.
        rand_rsp = 1'b0; lat_min = 3; lat_max = 3;
        go_idle(10);
        d_instr_ready = 1'b0; d_req_ready = 1'b1;
        repeat (4) step();
        check("pre_reset_work", {mq.size(), dq.size()}, {32'd1, 32'd1});
        apply_reset(2);
        step();
        check("rst_boot_no_req", s_req_valid, 1'b0);
        step();
        check("rst_first_req", {s_accept, s_req_addr}, {1'b1, RST_PC});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
